alu_exec_seq: RTL and testbench



---
 rtl/alu_exec_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_exec_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a registered result/zero.
// Define ALU_BARREL_SHIFT_EN to use a single-cycle barrel shifter instead of the iterative shifter.

`ifndef ADD
`define ADD  4'b0000
`endif
`ifndef SLL
`define SLL  4'b0001
`endif
`ifndef SLT
`define SLT  4'b0010
`endif
`ifndef SLTU
`define SLTU 4'b0011
`endif
`ifndef XOR
`define XOR  4'b0100
`endif
`ifndef SRL
`define SRL  4'b0101
`endif
`ifndef OR
`define OR   4'b0110
`endif
`ifndef AND
`define AND  4'b0111
`endif
`ifndef SUB
`define SUB  4'b1000
`endif
`ifndef SRA
`define SRA  4'b1101
`endif

// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// out_valid never drops and result never changes until out_valid & out_ready.
module alu_exec_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] result_q, res_next;
  logic            zero_q;
  logic            res_we;
  logic            accept;
  logic [XLEN-1:0] alu_out;
  logic [4:0]      shamt;

  assign shamt     = op_b[4:0];
  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign state_dbg = state;

  always_comb begin
    alu_out = op_a + op_b;
    case (alu_ctrl)
      `ADD:  alu_out = op_a + op_b;
      `SUB:  alu_out = op_a - op_b;
      `SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      `SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      `XOR:  alu_out = op_a ^ op_b;
      `OR:   alu_out = op_a | op_b;
      `AND:  alu_out = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
      `SLL:  alu_out = op_a << shamt;
      `SRL:  alu_out = op_a >> shamt;
      `SRA:  alu_out = XLEN'($signed(op_a) >>> shamt);
`endif
      default: alu_out = op_a + op_b;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  always_comb begin
    state_next = state;
    res_next   = result_q;
    res_we     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          res_next   = alu_out;
          res_we     = 1'b1;
          state_next = DONE;
        end else if (state == DONE && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (res_we) begin
        result_q <= res_next;
        zero_q   <= (res_next == '0);
      end
    end
  end

`else

  logic [4:0]      cnt_q, cnt_next;
  logic [3:0]      op_q, op_next;
  logic [XLEN-1:0] shift_out;
  logic            is_shift;

  assign is_shift = (alu_ctrl == `SLL) || (alu_ctrl == `SRL) || (alu_ctrl == `SRA);

  always_comb begin
    case (op_q)
      `SLL:    shift_out = {result_q[XLEN-2:0], 1'b0};
      `SRL:    shift_out = {1'b0, result_q[XLEN-1:1]};
      default: shift_out = {result_q[XLEN-1], result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_next = state;
    res_next   = result_q;
    res_we     = 1'b0;
    cnt_next   = cnt_q;
    op_next    = op_q;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          res_we = 1'b1;
          if (is_shift) begin
            res_next   = op_a;
            cnt_next   = shamt;
            op_next    = alu_ctrl;
            state_next = (shamt == 5'd0) ? DONE : SHIFT;
          end else begin
            res_next   = alu_out;
            state_next = DONE;
          end
        end else if (state == DONE && out_ready) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        // One bit per cycle; leaving on the edge where the counter hits zero.
        res_next = shift_out;
        res_we   = 1'b1;
        cnt_next = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= 5'd0;
      op_q     <= `ADD;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      op_q  <= op_next;
      if (res_we) begin
        result_q <= res_next;
        zero_q   <= (res_next == '0);
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: driver tasks push expected results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_exec_seq;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_UNDEF = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  alu_exec_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic int shift_lat(input int k);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an op, wait (bounded) for acceptance, push the expected response.
  task automatic send(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res);
    int n;
    in_valid = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept"}, {31'b0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back({(exp_res == 32'd0), exp_res});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid; in_ready must be low meanwhile.
  task automatic wait_valid(input string name, input int exp_n);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      check({name, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
    end
    check({name, "_latency"}, n, exp_n);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected actual=0x%08h zero=%0b expected=none", result, zero);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({zero, result} !== e) begin
          errors++;
          $display("FAIL monitor_result actual=0x%08h zero=%0b expected=0x%08h zero=%0b",
                   result, zero, e[31:0], e[32]);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = OP_ADD;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_state", {30'b0, state_dbg}, 32'd0);

    step();
    send("add", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    wait_valid("add", 1);
    step();
    send("sub", OP_SUB, 32'd5, 32'd5, 32'd0);
    wait_valid("sub", 1);
    step();
    send("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    wait_valid("slt", 1);
    step();
    send("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    wait_valid("sltu", 1);
    step();
    send("undef", OP_UNDEF, 32'd2, 32'd3, 32'd5);
    wait_valid("undef", 1);
    step();
    send("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    wait_valid("and", 1);

    step();
    send("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    wait_valid("sra31", shift_lat(31));
    step();
    send("sll0", OP_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
    wait_valid("sll0", shift_lat(0));
    step();
    send("sll4", OP_SLL, 32'd1, 32'd4, 32'h0000_0010);
    wait_valid("sll4", shift_lat(4));
    step();
    send("srl4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    wait_valid("srl4", shift_lat(4));

    // Backpressure then a back-to-back accept in the releasing cycle.
    step();
    out_ready = 1'b0;
    send("bp_add", OP_ADD, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'h0000_1234);
      check("bp_zero", {31'b0, zero}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1'b1;
    send("b2b_xor", OP_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F);
    wait_valid("b2b_xor", 1);

    // Reset in the middle of a long shift discards it.
    step();
    send("rst_srl", OP_SRL, 32'hFFFF_0000, 32'd20, 32'h0000_0FFF);
    repeat (8) step();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_out_valid_pre", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    step();
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'b0, zero}, 32'd0);
    check("midrst_state", {30'b0, state_dbg}, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    out_ready = 1'b1;
    send("or", OP_OR, 32'd1, 32'd2, 32'd3);
    wait_valid("or", 1);

    repeat (3) step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
